mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-port arbiter that shares the single slow_memory block (128-bit line, `mem_ready` handshake) between the I-cache (port 0) and the D-cache (port 1).
- Serialises requests, registers all memory-side command outputs, and routes the one-cycle `mem_ready` pulse and the read data back to the granted requester only.
- Sits between the two cache controllers and the memory model in the CPU top level.

Parameters:
- ADDR_W, 28, line (block) address width; matches the memory's `mem_addr`.
- DATA_W, 128, line data width.

Ports:
- clk  input  1  system clock; all arbiter state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- p0_read  input  1  port 0 read request; held until p0_ready.
- p0_write  input  1  port 0 write request; held until p0_ready.
- p0_addr  input  ADDR_W  port 0 line address.
- p0_wdata  input  DATA_W  port 0 write line.
- p0_rdata  output  DATA_W  port 0 read line, registered.
- p0_ready  output  1  port 0 completion pulse.
- p1_read, p1_write, p1_addr, p1_wdata, p1_rdata, p1_ready  same as port 0, for port 1.
- mem_read  output  1  to memory, registered.
- mem_write  output  1  to memory, registered.
- mem_addr  output  ADDR_W  to memory, registered.
- mem_wdata  output  DATA_W  to memory, registered.
- mem_rdata  input  DATA_W  from memory.
- mem_ready  input  1  from memory; one-cycle pulse per transaction.
- grant  output  2  one-hot owner of the current transaction; 00 when idle.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - mem_read/mem_write/mem_addr/mem_wdata=0.
  - p0/p1 ready=0 and rdata=0.
  - grant=00; last-served pointer=port 0.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - A port is requesting if its read|write=1.
  - If any port is requesting, select a winner and latch its addr/wdata/command into the mem_* registers, set grant, go to WAIT.
  - Memory sees the command one cycle after the request is sampled.
  - mem_ready is ignored in IDLE; a stale pulse after a mid-transaction reset must not complete anything.
- Selection: fixed priority, port 1 (D-cache) wins when both ports request.
- Command encoding:
  - If the winner asserts both read and write, drive mem_write=1, mem_read=0; no data is returned.
  - Never drive mem_read and mem_write high together.
- WAIT:
  - Hold all mem_* outputs stable.
  - On mem_ready=1 at posedge:
    - clear mem_read/mem_write;
    - for a read, load mem_rdata into the winner's rdata register;
    - set the winner's ready=1;
    - go to DONE.
  - No timeout: WAIT persists until mem_ready.
- DONE:
  - Winner's ready is high for exactly this one cycle; clear it on exit.
  - grant -> 00; update the last-served pointer.
  - Requests are not sampled in DONE, so the requester drops its request at the end of this cycle.
  - Next state: IDLE.
- Latency:
  - Request sampled at edge N, mem_read high from N+1.
  - pX_ready is high in the cycle after the edge that samples mem_ready.
  - Minimum idle gap between two memory commands: 2 cycles (DONE, IDLE), which guarantees the memory returns to its idle state with request low.
- pX_rdata: changes only on completion of that port's read; otherwise holds its value, including across writes and other-port transactions.
- The non-granted port's ready is always 0; its request stays pending with no loss.
- Request dropped mid-WAIT: the transaction completes anyway; the ready pulse is still issued.
- Reset mid-transaction: all outputs clear immediately; requesters re-issue.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: when both ports request in IDLE, the port not served last wins; a single requester always wins regardless of the pointer.
- Undefined: fixed priority as above, port 1 always wins ties; the pointer is still maintained but unused.

Test Plan:
- Port 0 read addr 28'h10, memory preloaded 128'hA5..A5 -> mem_read=1 with mem_addr=28'h10 one cycle later, grant=01; p0_ready pulses one cycle with p0_rdata=128'hA5..A5; p1_ready stays 0.
- Port 1 write addr 28'h20 data 128'h1234, then port 1 read 28'h20 -> mem_write then mem_read never overlap; read returns 128'h1234.
- Both ports read the same cycle, fixed priority -> port 1 served first and port 0 second, with ≥2 idle cycles between mem commands. With ARB_ROUND_ROBIN_EN and last-served=1, port 0 is served first.
- Port 0 asserts read and write together -> only mem_write=1; p0_rdata unchanged; p0_ready pulses once.
- rst_n dropped in WAIT, memory pulses mem_ready 3 cycles after release -> all outputs 0 immediately; the stale pulse is ignored, with no pX_ready and no rdata change.
- Port 1 holds write continuously for 3 transactions -> exactly 3 memory commands and 3 ready pulses; no command is issued during any DONE cycle.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one line-wide slow memory between the I-cache (port 0)
// and the D-cache (port 1). Requests are serialised through IDLE -> WAIT -> DONE.
// All memory-side commands are registered. The mem_ready pulse and the read data
// go back only to the port that holds the grant.
// Optional feature: define ARB_ROUND_ROBIN_EN to break ties toward the port that
// was not served last. When the macro is undefined, port 1 always wins a tie.
module mem_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_read,
  input  logic              p0_write,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_ready,
  input  logic              p1_read,
  input  logic              p1_write,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [1:0]        grant
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_e;

  state_e state_q, state_d;

  logic              mem_read_q,  mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [1:0]        grant_q,     grant_d;
  logic [DATA_W-1:0] p0_rdata_q,  p0_rdata_d;
  logic [DATA_W-1:0] p1_rdata_q,  p1_rdata_d;
  logic              p0_ready_q,  p0_ready_d;
  logic              p1_ready_q,  p1_ready_d;
  logic              last_q,      last_d;  // 1 = port 1 was served last

  logic req0, req1, pick1;

  assign req0 = p0_read | p0_write;
  assign req1 = p1_read | p1_write;

  // A lone requester always wins. Only the tie-break depends on the build.
`ifdef ARB_ROUND_ROBIN_EN
  assign pick1 = req1 & (~req0 | ~last_q);
`else
  assign pick1 = req1;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic. mem_ready only matters in WAIT, so a stale pulse
  // arriving in IDLE completes nothing.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req0 | req1) state_d = S_WAIT;
      S_WAIT:  if (mem_ready)   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output next-state: latch the winner's command, route completion, retire grant
  always_comb begin
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    grant_d     = grant_q;
    p0_rdata_d  = p0_rdata_q;
    p1_rdata_d  = p1_rdata_q;
    p0_ready_d  = p0_ready_q;
    p1_ready_d  = p1_ready_q;
    last_d      = last_q;
    case (state_q)
      S_IDLE: begin
        if (req0 | req1) begin
          mem_addr_d  = pick1 ? p1_addr  : p0_addr;
          mem_wdata_d = pick1 ? p1_wdata : p0_wdata;
          // A write takes precedence when both are asserted, so the two
          // commands are never driven together.
          mem_write_d = pick1 ? p1_write : p0_write;
          mem_read_d  = pick1 ? (p1_read & ~p1_write) : (p0_read & ~p0_write);
          grant_d     = pick1 ? 2'b10 : 2'b01;
        end
      end
      S_WAIT: begin
        if (mem_ready) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          if (grant_q[0]) begin
            p0_ready_d = 1'b1;
            if (mem_read_q) p0_rdata_d = mem_rdata;
          end
          if (grant_q[1]) begin
            p1_ready_d = 1'b1;
            if (mem_read_q) p1_rdata_d = mem_rdata;
          end
        end
      end
      S_DONE: begin
        p0_ready_d = 1'b0;
        p1_ready_d = 1'b0;
        grant_d    = 2'b00;
        last_d     = grant_q[1];
      end
      default: ;
    endcase
  end

  // Output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      grant_q     <= 2'b00;
      p0_rdata_q  <= '0;
      p1_rdata_q  <= '0;
      p0_ready_q  <= 1'b0;
      p1_ready_q  <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      grant_q     <= grant_d;
      p0_rdata_q  <= p0_rdata_d;
      p1_rdata_q  <= p1_rdata_d;
      p0_ready_q  <= p0_ready_d;
      p1_ready_q  <= p1_ready_d;
      last_q      <= last_d;
    end
  end

  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign grant     = grant_q;
  assign p0_rdata  = p0_rdata_q;
  assign p1_rdata  = p1_rdata_q;
  assign p0_ready  = p0_ready_q;
  assign p1_ready  = p1_ready_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. A small line memory answers commands after a
// fixed latency. A monitor records command starts, grant order, gaps and overlaps.
module tb_mem_arbiter;
  localparam int AW = 28;
  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          p0_read, p0_write, p1_read, p1_write;
  logic [AW-1:0] p0_addr, p1_addr, mem_addr;
  logic [DW-1:0] p0_wdata, p1_wdata, p0_rdata, p1_rdata, mem_wdata, mem_rdata;
  logic          p0_ready, p1_ready, mem_read, mem_write, mem_ready;
  logic [1:0]    grant;

  int total = 0;
  int bad   = 0;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_read(p0_read), .p0_write(p0_write), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_rdata(p0_rdata), .p0_ready(p0_ready),
    .p1_read(p1_read), .p1_write(p1_write), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_rdata(p1_rdata), .p1_ready(p1_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .grant(grant)
  );

  always #5 clk = ~clk;

  // Memory model: answers a command 3 negedges after it appears.
  logic [DW-1:0] mem [logic [AW-1:0]];
  bit auto_mem = 1'b1;
  int lat_cnt  = 0;
  always @(negedge clk) begin
    if (auto_mem) begin
      mem_ready = 1'b0;
      if (mem_read || mem_write) begin
        if (lat_cnt == 2) begin
          mem_ready = 1'b1;
          lat_cnt   = 0;
          if (mem_write) mem[mem_addr] = mem_wdata;
          else mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : '0;
        end else lat_cnt++;
      end else lat_cnt = 0;
    end else lat_cnt = 0;
  end

  // Monitor
  int         cmd_cnt  = 0;
  int         idle_run = 0;
  int         min_gap  = 1000;
  bit         prev_cmd = 1'b0;
  bit         overlap  = 1'b0;
  bit         cmd_in_done = 1'b0;
  logic [1:0] order[$];
  always @(negedge clk) begin
    bit cmd;
    cmd = mem_read || mem_write;
    if (cmd && !prev_cmd) begin
      if (cmd_cnt > 0 && idle_run < min_gap) min_gap = idle_run;
      cmd_cnt++;
      order.push_back(grant);
    end
    idle_run = cmd ? 0 : idle_run + 1;
    prev_cmd = cmd;
    if (mem_read && mem_write) overlap = 1'b1;
    if ((p0_ready || p1_ready) && cmd) cmd_in_done = 1'b1;
  end

  task automatic wait_rdy(input int port, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if ((port == 0 && p0_ready) || (port == 1 && p1_ready)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++; if ({mem_read, mem_write} !== 2'b00) begin bad++; $display("FAIL reset_cmd: got %b want 00", {mem_read, mem_write}); end
    total++; if (mem_addr !== '0 || mem_wdata !== '0) begin bad++; $display("FAIL reset_addr: got %h/%h want 0", mem_addr, mem_wdata); end
    total++; if (grant !== 2'b00) begin bad++; $display("FAIL reset_grant: got %b want 00", grant); end
    total++; if ({p0_ready, p1_ready} !== 2'b00) begin bad++; $display("FAIL reset_ready: got %b want 00", {p0_ready, p1_ready}); end
    total++; if (p0_rdata !== '0 || p1_rdata !== '0) begin bad++; $display("FAIL reset_rdata: got %h/%h want 0", p0_rdata, p1_rdata); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_p0_read();
    bit ok;
    mem[28'h10] = {16{8'hA5}};
    p0_addr = 28'h10; p0_read = 1'b1;
    @(negedge clk);
    total++; if ({mem_read, mem_write} !== 2'b10) begin bad++; $display("FAIL p0rd_cmd: got %b want 10", {mem_read, mem_write}); end
    total++; if (mem_addr !== 28'h10) begin bad++; $display("FAIL p0rd_addr: got %h want 10", mem_addr); end
    total++; if (grant !== 2'b01) begin bad++; $display("FAIL p0rd_grant: got %b want 01", grant); end
    wait_rdy(0, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL p0rd_timeout: got %b want 1", ok); end
    total++; if (p0_rdata !== {16{8'hA5}}) begin bad++; $display("FAIL p0rd_data: got %h want a5..a5", p0_rdata); end
    total++; if (p1_ready !== 1'b0) begin bad++; $display("FAIL p0rd_p1rdy: got %b want 0", p1_ready); end
    p0_read = 1'b0;
    @(negedge clk);
    total++; if ({p0_ready, grant} !== 3'b000) begin bad++; $display("FAIL p0rd_after: got %b want 000", {p0_ready, grant}); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_p1_write_read();
    bit ok;
    p1_addr = 28'h20; p1_wdata = 128'h1234; p1_write = 1'b1;
    @(negedge clk);
    total++; if ({mem_read, mem_write, grant} !== 4'b0110) begin bad++; $display("FAIL p1wr_cmd: got %b want 0110", {mem_read, mem_write, grant}); end
    wait_rdy(1, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL p1wr_timeout: got %b want 1", ok); end
    p1_write = 1'b0;
    @(negedge clk);
    p1_read = 1'b1;
    wait_rdy(1, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL p1rd_timeout: got %b want 1", ok); end
    total++; if (p1_rdata !== 128'h1234) begin bad++; $display("FAIL p1rd_data: got %h want 1234", p1_rdata); end
    p1_read = 1'b0;
    @(negedge clk);
    total++; if (overlap !== 1'b0) begin bad++; $display("FAIL p1_overlap: got %b want 0", overlap); end
    total++; if (p0_rdata !== {16{8'hA5}}) begin bad++; $display("FAIL p0_hold: got %h want a5..a5", p0_rdata); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_both_read();
    bit ok;
    int first;
    logic [1:0] g0, g1, e0, e1;
`ifdef ARB_ROUND_ROBIN_EN
    e0 = 2'b01; e1 = 2'b10;
`else
    e0 = 2'b10; e1 = 2'b01;
`endif
    mem[28'h30] = {16{8'hC3}};
    mem[28'h40] = {16{8'h3C}};
    order.delete();
    p0_addr = 28'h30; p1_addr = 28'h40;
    p0_read = 1'b1; p1_read = 1'b1;
    first = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (p0_ready || p1_ready) begin first = p1_ready ? 1 : 0; break; end
    end
    total++; if (first !== (e0 == 2'b10 ? 1 : 0)) begin bad++; $display("FAIL both_first: got %0d want %0d", first, (e0 == 2'b10 ? 1 : 0)); end
    if (first == 1) p1_read = 1'b0; else p0_read = 1'b0;
    wait_rdy(first == 1 ? 0 : 1, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL both_second_timeout: got %b want 1", ok); end
    p0_read = 1'b0; p1_read = 1'b0;
    @(negedge clk);
    g0 = order.size() > 0 ? order[0] : 2'bxx;
    g1 = order.size() > 1 ? order[1] : 2'bxx;
    total++; if (order.size() !== 2) begin bad++; $display("FAIL both_cmds: got %0d want 2", order.size()); end
    total++; if ({g0, g1} !== {e0, e1}) begin bad++; $display("FAIL both_order: got %b want %b", {g0, g1}, {e0, e1}); end
    total++; if (p0_rdata !== {16{8'hC3}} || p1_rdata !== {16{8'h3C}}) begin bad++; $display("FAIL both_data: got %h/%h want c3../3c..", p0_rdata, p1_rdata); end
    total++; if ((min_gap >= 2) !== 1'b1) begin bad++; $display("FAIL both_gap: got %0d want >=2", min_gap); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_rw_both();
    bit ok;
    p0_addr = 28'h50; p0_wdata = 128'h77; p0_read = 1'b1; p0_write = 1'b1;
    @(negedge clk);
    total++; if ({mem_read, mem_write} !== 2'b01) begin bad++; $display("FAIL rw_cmd: got %b want 01", {mem_read, mem_write}); end
    wait_rdy(0, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL rw_timeout: got %b want 1", ok); end
    total++; if (p0_rdata !== {16{8'hC3}}) begin bad++; $display("FAIL rw_rdata: got %h want c3..c3", p0_rdata); end
    p0_read = 1'b0; p0_write = 1'b0;
    @(negedge clk);
    total++; if (p0_ready !== 1'b0) begin bad++; $display("FAIL rw_pulse: got %b want 0", p0_ready); end
    total++; if (mem[28'h50] !== 128'h77) begin bad++; $display("FAIL rw_mem: got %h want 77", mem[28'h50]); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit seen;
    auto_mem = 1'b0; mem_ready = 1'b0;
    p1_addr = 28'h60; p1_read = 1'b1;
    @(negedge clk);
    total++; if ({mem_read, grant} !== 3'b110) begin bad++; $display("FAIL rst_wait: got %b want 110", {mem_read, grant}); end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++; if ({mem_read, mem_write, grant, p0_ready, p1_ready} !== 6'b0) begin bad++; $display("FAIL rst_ctl: got %b want 0", {mem_read, mem_write, grant, p0_ready, p1_ready}); end
    total++; if (mem_addr !== '0 || p1_rdata !== '0 || p0_rdata !== '0) begin bad++; $display("FAIL rst_data: got %h/%h/%h want 0", mem_addr, p0_rdata, p1_rdata); end
    p1_read = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    mem_rdata = {8{16'hDEAD}}; mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (p0_ready || p1_ready || grant != 2'b00 || mem_read || mem_write) seen = 1'b1;
      @(negedge clk);
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL rst_stale: got %b want 0", seen); end
    total++; if (p1_rdata !== '0 || p0_rdata !== '0) begin bad++; $display("FAIL rst_stale_data: got %h/%h want 0", p0_rdata, p1_rdata); end
    auto_mem = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int c0, n, p0n;
    c0 = cmd_cnt; n = 0; p0n = 0;
    cmd_in_done = 1'b0;
    p1_addr = 28'h70; p1_wdata = 128'h55; p1_write = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (p0_ready) p0n++;
      if (p1_ready) n++;
      if (n == 3) break;
    end
    p1_write = 1'b0;
    repeat (4) @(negedge clk);
    total++; if (n !== 3) begin bad++; $display("FAIL b2b_ready: got %0d want 3", n); end
    total++; if (cmd_cnt - c0 !== 3) begin bad++; $display("FAIL b2b_cmds: got %0d want 3", cmd_cnt - c0); end
    total++; if (cmd_in_done !== 1'b0) begin bad++; $display("FAIL b2b_done_cmd: got %b want 0", cmd_in_done); end
    total++; if (p0n !== 0) begin bad++; $display("FAIL b2b_p0rdy: got %0d want 0", p0n); end
  endtask

  initial begin
    p0_read = 1'b0; p0_write = 1'b0; p0_addr = '0; p0_wdata = '0;
    p1_read = 1'b0; p1_write = 1'b0; p1_addr = '0; p1_wdata = '0;
    mem_rdata = '0; mem_ready = 1'b0;
    test_reset();
    test_p0_read();
    test_p1_write_read();
    test_both_read();
    test_rw_both();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
